// File: rtl/chess_pkg.sv
// Shared types, palette and default board geometry for the chess pixel renderer.
package chess_pkg;

    localparam int DEF_BOARD_X0 = 96;
    localparam int DEF_BOARD_Y0 = 16;
    localparam int DEF_SQ       = 56;
    localparam int DEF_SPR_OFF  = 12;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6,
        NONE7  = 3'd7
    } piece_type_e;

    typedef struct packed {
        logic        black;
        piece_type_e ptype;
    } piece_t;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COL_OUTSIDE = 12'h222;
    localparam rgb_t COL_CURSOR  = 12'hFF0;
    localparam rgb_t COL_FILL_W  = 12'hFFF;
    localparam rgb_t COL_FILL_B  = 12'h111;
    localparam rgb_t COL_LINE_W  = 12'h000;
    localparam rgb_t COL_LINE_B  = 12'h888;
    localparam rgb_t COL_SEL     = 12'h6C6;
    localparam rgb_t COL_LIGHT   = 12'hEC9;
    localparam rgb_t COL_DARK    = 12'hB85;

    // Type code 7 is unused by the board logic and renders like an empty square.
    function automatic logic is_drawn(input piece_type_e t);
        return (t != EMPTY) && (t != NONE7);
    endfunction

endpackage

// File: rtl/chess_pixel_pipeline_if.sv
// Sprite ROM bus: address out of the renderer, 2-bit pixel code back one cycle later.
interface chess_pixel_pipeline_if;
    logic [12:0] spr_addr;
    logic [1:0]  spr_data;

    modport master (output spr_addr, input spr_data);
    modport slave  (input spr_addr, output spr_data);
endinterface

// File: rtl/board_ram.sv
// 64 x 4-bit board state store: synchronous write, registered read, synchronous clear.
module board_ram (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_addr,
    input  logic [3:0] i_wr_data,
    input  logic [5:0] i_rd_addr,
    output logic [3:0] o_rd_data
);
    logic [3:0] r_mem [64];
    logic [3:0] r_rd_data;

    // A read of the square being written in the same cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 64; i++) begin
                r_mem[i] <= 4'd0;
            end
            r_rd_data <= 4'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/chess_pixel_pipeline.sv
// Per-pixel chess board renderer: geometry tracking, board lookup, sprite fetch and
// colour priority, with sync signals delayed to stay aligned with the colour output.
module chess_pixel_pipeline
    import chess_pkg::*;
#(
    parameter int BOARD_X0 = DEF_BOARD_X0,
    parameter int BOARD_Y0 = DEF_BOARD_Y0,
    parameter int SQ       = DEF_SQ,
    parameter int SPR_OFF  = DEF_SPR_OFF
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       wr_en,
    input  logic [5:0] wr_sq,
    input  logic [3:0] wr_piece,
    input  logic [5:0] cursor_sq,
    input  logic       sel_valid,
    input  logic [5:0] sel_sq,
    chess_pixel_pipeline_if.master spr,
    output logic [3:0] IDX_Red,
    output logic [3:0] IDX_Green,
    output logic [3:0] IDX_Blue,
    output logic       blank_out,
    output logic       hs_out,
    output logic       vs_out
);
    localparam logic [9:0] X_LO      = 10'(BOARD_X0);
    localparam logic [9:0] X_HI      = 10'(BOARD_X0 + 8 * SQ - 1);
    localparam logic [9:0] Y_LO      = 10'(BOARD_Y0);
    localparam logic [9:0] Y_HI      = 10'(BOARD_Y0 + 8 * SQ - 1);
    localparam logic [5:0] OFF_LAST  = 6'(SQ - 1);
    localparam logic [5:0] BORDER_HI = 6'(SQ - 4);
    localparam logic [5:0] WIN_LO    = 6'(SPR_OFF);
    localparam logic [5:0] WIN_HI    = 6'(SPR_OFF + 31);

    logic [5:0] w_xoff, w_yoff;
    logic [2:0] w_file, w_row;
    logic       w_in_board;
    logic [5:0] r_yoff;
    logic [2:0] r_row;

    logic       r_s0_v, r_s0_in;
    logic [5:0] r_s0_xoff, r_s0_yoff, r_s0_sq;
    logic [2:0] r_s0_file, r_s0_rank;
    logic [3:0] w_ram_q;

    logic       r_vs_prev, r_sel_valid;
    logic [5:0] r_cursor, r_sel_sq;

    // The S0 x registers double as the column counter for the next pixel.
    always_comb begin
        w_xoff = 6'd0;
        w_file = 3'd0;
        if (DrawX != X_LO) begin
            if (r_s0_xoff == OFF_LAST) begin
                w_file = r_s0_file + 3'd1;
            end else begin
                w_xoff = r_s0_xoff + 6'd1;
                w_file = r_s0_file;
            end
        end
        w_yoff = r_yoff;
        w_row  = r_row;
        if (DrawX == 10'd0) begin
            if (DrawY == Y_LO) begin
                w_yoff = 6'd0;
                w_row  = 3'd0;
            end else if (r_yoff == OFF_LAST) begin
                w_yoff = 6'd0;
                w_row  = r_row + 3'd1;
            end else begin
                w_yoff = r_yoff + 6'd1;
            end
        end
        w_in_board = (DrawX >= X_LO) && (DrawX <= X_HI) && (DrawY >= Y_LO) && (DrawY <= Y_HI);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_yoff    <= 6'd0;
            r_row     <= 3'd0;
            r_s0_v    <= 1'b0;
            r_s0_in   <= 1'b0;
            r_s0_xoff <= 6'd0;
            r_s0_yoff <= 6'd0;
            r_s0_file <= 3'd0;
            r_s0_rank <= 3'd0;
            r_s0_sq   <= 6'd0;
        end else begin
            r_yoff    <= w_yoff;
            r_row     <= w_row;
            r_s0_v    <= 1'b1;
            r_s0_in   <= w_in_board;
            r_s0_xoff <= w_xoff;
            r_s0_yoff <= w_yoff;
            r_s0_file <= w_file;
            r_s0_rank <= 3'd7 - w_row;
            r_s0_sq   <= {3'd7 - w_row, w_file};
        end
    end

    board_ram u_board_ram (
        .clk       (pixel_clk),
        .srst      (reset),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_sq),
        .i_wr_data (wr_piece),
        .i_rd_addr ({3'd7 - w_row, w_file}),
        .o_rd_data (w_ram_q)
    );

    // Cursor and selection only change on a vsync rising edge so they never tear.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_vs_prev   <= 1'b1;
            r_cursor    <= 6'd0;
            r_sel_valid <= 1'b0;
            r_sel_sq    <= 6'd0;
        end else begin
            r_vs_prev <= vs_in;
            if (vs_in && !r_vs_prev) begin
                r_cursor    <= cursor_sq;
                r_sel_valid <= sel_valid;
                r_sel_sq    <= sel_sq;
            end
        end
    end

    piece_t      w_piece;
    logic        w_border, w_win, w_draw;
    rgb_t        w_bg;
    logic [12:0] w_spr_addr;

    always_comb begin
        w_piece  = piece_t'(w_ram_q);
        w_border = (r_s0_sq == r_cursor) &&
                   ((r_s0_xoff < 6'd3) || (r_s0_xoff > BORDER_HI) ||
                    (r_s0_yoff < 6'd3) || (r_s0_yoff > BORDER_HI));
        w_win    = (r_s0_xoff >= WIN_LO) && (r_s0_xoff <= WIN_HI) &&
                   (r_s0_yoff >= WIN_LO) && (r_s0_yoff <= WIN_HI);
        w_draw   = r_s0_in && !w_border && w_win && is_drawn(w_piece.ptype);
        if (!r_s0_in)                                 w_bg = COL_OUTSIDE;
        else if (w_border)                            w_bg = COL_CURSOR;
        else if (r_sel_valid && r_s0_sq == r_sel_sq)  w_bg = COL_SEL;
        else if (r_s0_rank[0] ^ r_s0_file[0])         w_bg = COL_LIGHT;
        else                                          w_bg = COL_DARK;
        w_spr_addr = 13'd0;
        if (w_draw) begin
            w_spr_addr = {w_piece.ptype, 5'(r_s0_yoff - WIN_LO), 5'(r_s0_xoff - WIN_LO)};
        end
    end

    logic [12:0] r_spr_addr;
    logic        r_s2_v, r_s2_draw, r_s2_black, r_s3_v, r_s3_draw, r_s3_black;
    rgb_t        r_s2_bg, r_s3_bg, r_rgb, w_rgb;
    logic [3:0][2:0] r_sync;

    // Piece pixels override everything below the cursor border, which w_draw already excludes.
    always_comb begin
        w_rgb = r_s3_bg;
        if (r_s3_draw && spr.spr_data != 2'b00) begin
            if (spr.spr_data == 2'b01) w_rgb = r_s3_black ? COL_LINE_B : COL_LINE_W;
            else                       w_rgb = r_s3_black ? COL_FILL_B : COL_FILL_W;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_spr_addr <= 13'd0;
            r_s2_v     <= 1'b0;
            r_s2_draw  <= 1'b0;
            r_s2_black <= 1'b0;
            r_s2_bg    <= 12'h000;
            r_s3_v     <= 1'b0;
            r_s3_draw  <= 1'b0;
            r_s3_black <= 1'b0;
            r_s3_bg    <= 12'h000;
            r_rgb      <= 12'h000;
            r_sync     <= {4{3'b011}};
        end else begin
            r_spr_addr <= w_spr_addr;
            r_s2_v     <= r_s0_v;
            r_s2_draw  <= w_draw;
            r_s2_black <= w_piece.black;
            r_s2_bg    <= w_bg;
            r_s3_v     <= r_s2_v;
            r_s3_draw  <= r_s2_draw;
            r_s3_black <= r_s2_black;
            r_s3_bg    <= r_s2_bg;
            r_rgb      <= r_s3_v ? w_rgb : 12'h000;
            r_sync     <= {r_sync[2:0], {blank_in, hs_in, vs_in}};
        end
    end

    assign spr.spr_addr = r_spr_addr;
    assign IDX_Red      = r_rgb[11:8];
    assign IDX_Green    = r_rgb[7:4];
    assign IDX_Blue     = r_rgb[3:0];
    assign blank_out    = r_sync[3][2];
    assign hs_out       = r_sync[3][1];
    assign vs_out       = r_sync[3][0];
endmodule

// File: doc/chess_pixel_pipeline.md
# chess_pixel_pipeline

Per-pixel renderer for the chess board display, directly upstream of the colour mapper. Consumes raster position and sync/blank from the VGA timing generator, holds the 64-square board state written by the CPU-side logic, fetches piece sprite bits from an external sprite ROM, and produces 4-bit IDX_Red/IDX_Green/IDX_Blue plus delayed blank/hs/vs, all aligned, with a fixed 4-cycle latency.

## Interface
- BOARD_X0, 96: first board pixel column
- BOARD_Y0, 16: first board pixel row
- SQ, 56: square size in pixels (board is 8*SQ square)
- SPR_OFF, 12: sprite offset inside a square (32x32 sprite)
- pixel_clk  in  1  single clock
- reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current raster position
- blank_in, hs_in, vs_in  in  1 each  from timing generator (blank active-low, as consumed downstream)
- wr_en  in  1  board state write strobe
- wr_sq  in  6  square index {rank[2:0], file[2:0]}, 0 = a1 at bottom-left
- wr_piece  in  4  bit3 colour (1 = black), [2:0] type: 0 empty, 1..6 pawn..king, 7 treated as empty
- cursor_sq  in  6  cursor square
- sel_valid  in  1  a square is selected
- sel_sq  in  6  selected square
- spr_addr  out  13  {type[2:0], row[4:0], col[4:0]} to sprite ROM
- spr_data  in  2  ROM data, valid one cycle after spr_addr: 00 transparent, 01 outline, 10 fill, 11 fill
- IDX_Red, IDX_Green, IDX_Blue  out  4 each  pixel colour
- blank_out, hs_out, vs_out  out  1 each  sync delayed to match colour

## Operation
- Board RAM: 64x4 register array; reset clears all to 0 (empty). Write takes effect the cycle after wr_en. Same-cycle read of a square being written returns the old value.
- Cursor/selection shadow registers: cursor_sq, sel_valid, sel_sq are sampled on the rising edge of vs_in (vs_in low then high); displayed values change only then. Reset: cursor 0, sel_valid 0, sel_sq 0.
- Geometry tracking (incremental counters, no dividers): x offset/file counters clear when DrawX==BOARD_X0, advance each pixel, offset wraps SQ-1 -> 0 with file+1; y offset/rank-row counters clear when DrawX==0 && DrawY==BOARD_Y0, advance on DrawX==0 for each later line. in_board = DrawX in [BOARD_X0, BOARD_X0+8*SQ-1] and DrawY in [BOARD_Y0, BOARD_Y0+8*SQ-1]. Displayed rank = 7 - row counter.
- Pipeline stages: S0 register position/offsets/in_board; S1 board RAM read; S2 drive spr_addr (sprite row/col = offset - SPR_OFF when offset in [SPR_OFF, SPR_OFF+31], else mark transparent); S3 spr_data arrives, colour composed; S4 output register.
- Colour priority (highest first): outside board {2,2,2}; cursor border (square==cursor and either offset <3 or >SQ-4) {F,F,0}; piece pixel (type 1..6, in sprite window, spr_data!=00): fill white {F,F,F} / black {1,1,1}, outline white-piece {0,0,0} / black-piece {8,8,8}; selected square (sel_valid, square==sel) {6,C,6}; light square ((rank+file) odd) {E,C,9}; dark {B,8,5}.
- blank_out/hs_out/vs_out: blank_in/hs_in/vs_in delayed exactly 4 cycles; colour not forced by blank here (downstream handles it).

## Timing
- Latency DrawX/DrawY -> IDX_*: 4 pixel_clk cycles; blank/hs/vs identical latency. Throughput 1 pixel/cycle, no stalls.
- Reset values: IDX_* = 0, blank_out = 0, hs_out = 1, vs_out = 1, spr_addr = 0, all pipe valid bits 0.
- Reset mid-frame: pipeline flushes; first correct pixel 4 cycles after reset drops, geometry counters correct from next BOARD_X0 / BOARD_Y0 crossing.
- Write during active display: change visible for pixels whose S1 read is at least one cycle after the write cycle (tearing within frame accepted for board state, not for cursor/selection).

## Structure
- Package chess_pkg: piece type enum (EMPTY, PAWN..KING), piece_t struct {black, type}, palette constants (12-bit RGB localparams), geometry defaults.
- Sub-module board_ram (64x4, sync write, registered read, sync clear); rest in one module.

## Test plan
- Reset, then raster (0,0): after 4 cycles IDX = {2,2,2}, blank_out = delayed blank_in; all squares render as empty.
- Empty board, pixel (BOARD_X0, BOARD_Y0+8*SQ-1) = a1 (dark) -> {B,8,5}; neighbour square b1 -> {E,C,9}.
- Write wr_sq=0, wr_piece=4'b1110 (black king); ROM model returns 10 at sprite row 0 col 0: pixel (BOARD_X0+12, BOARD_Y0+7*SQ+12) -> spr_addr = {3'd6,5'd0,5'd0}, IDX = {1,1,1}.
- cursor_sq=9 changed mid-frame: no yellow until after next vs_in rising edge; then offset-0 pixel of b2 -> {F,F,0}, offset-3 pixel -> square/selection colour.
- sel_valid=1, sel_sq=cursor_sq: border yellow, interior {6,C,6}, piece pixels override green.
- Assert reset for 1 cycle mid-line: outputs reset values next cycle; hs/vs/blank alignment restored 4 cycles later.
